// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to the RX and TX paths.
// Pure declarations; no logic.
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
endpackage

// File: rtl/axi_fifo.sv
// AXI-stream FIFO of 2**SIZE entries; push accepted only when not full.
// Registered occupancy; simultaneous push and pop keeps the level constant.
module axi_fifo #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             o_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             i_tready,
  output logic [15:0]      o_occupied
);
  localparam int DEPTH = 1 << SIZE;
  localparam int PW    = (SIZE > 0) ? SIZE : 1;
  localparam int CW    = SIZE + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [2**PW];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_push     = i_tvalid && !w_full;
  assign w_pop      = (r_count != '0) && i_tready;
  assign o_tready   = !w_full;
  assign o_tvalid   = (r_count != '0);
  assign o_tdata    = r_mem[r_rd_ptr];
  assign o_occupied = 16'(r_count);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/axi_uart_rx.sv
// UART receiver: synchronises rx, deserialises 8N1 / 8[E|O]1 frames into an AXI-stream FIFO.
// Characters land in the FIFO one cycle after the mid-stop sample; a full FIFO drops the character and pulses overrun.
module axi_uart_rx
  import uart_pkg::*;
#(
  parameter int SIZE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  input  logic        o_tready,
  input  logic        parity_enable,
  input  logic        parity_type,
  input  logic [15:0] clkdiv,
  output logic [15:0] fifo_level,
  output logic        parity_error,
  output logic        framing_error,
  output logic        overrun,
  output logic        baudclk
);
  logic        r_rx_meta, r_rx_s, r_rx_d;
  logic [2:0]  r_state;
  logic [15:0] r_baud_ctr;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shreg;
  logic        r_par_bad;
  logic        r_push;
  logic        r_parity_error, r_framing_error, r_overrun;
  logic        w_mid, w_full_bit, w_sample, w_fifo_rdy;

  assign w_mid      = (r_baud_ctr == (clkdiv >> 1));
  assign w_full_bit = (r_baud_ctr == clkdiv);

  always_comb begin
    w_sample = 1'b0;
    case (r_state)
      ST_START:                     w_sample = w_mid;
      ST_DATA, ST_PARITY, ST_STOP:  w_sample = w_full_bit;
      default:                      w_sample = 1'b0;
    endcase
  end

  // Synchroniser resets high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta       <= 1'b1;
      r_rx_s          <= 1'b1;
      r_rx_d          <= 1'b1;
      r_state         <= ST_IDLE;
      r_baud_ctr      <= '0;
      r_bit_idx       <= '0;
      r_shreg         <= '0;
      r_par_bad       <= 1'b0;
      r_push          <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_rx_meta       <= rx;
      r_rx_s          <= r_rx_meta;
      r_rx_d          <= r_rx_s;
      r_push          <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
      if (r_state != ST_IDLE) r_baud_ctr <= r_baud_ctr + 16'd1;
      case (r_state)
        ST_IDLE: begin
          if (r_rx_d && !r_rx_s) begin
            r_baud_ctr <= 16'd1;
            r_par_bad  <= 1'b0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_mid) begin
            if (r_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_baud_ctr <= 16'd1;
              r_bit_idx  <= '0;
              r_state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_full_bit) begin
            r_shreg[r_bit_idx] <= r_rx_s;
            r_baud_ctr         <= 16'd1;
            if (r_bit_idx == 3'd7) r_state <= parity_enable ? ST_PARITY : ST_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        ST_PARITY: begin
          if (w_full_bit) begin
            r_par_bad  <= r_rx_s ^ (^r_shreg) ^ parity_type;
            r_baud_ctr <= 16'd1;
            r_state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (w_full_bit) begin
            r_state <= ST_IDLE;
            if (!r_rx_s)         r_framing_error <= 1'b1;
            else if (r_par_bad)  r_parity_error  <= 1'b1;
            else if (!w_fifo_rdy) r_overrun      <= 1'b1;
            else                 r_push          <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign parity_error  = r_parity_error;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;
  assign baudclk       = w_sample;

  axi_fifo #(
    .WIDTH (8),
    .SIZE  (SIZE)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_tdata    (r_shreg),
    .i_tvalid   (r_push),
    .o_tready   (w_fifo_rdy),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .i_tready   (o_tready),
    .o_occupied (fifo_level)
  );
endmodule

// File: tb/tb_axi_uart_rx.sv
// Scoreboard bench for axi_uart_rx: serial frames are generated here, expected bytes/errors queued,
// and a forked monitor compares every FIFO pop and error pulse against the queues.
module tb_axi_uart_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic        o_tready;
  logic        parity_enable;
  logic        parity_type;
  logic [15:0] clkdiv;
  logic [15:0] fifo_level;
  logic        parity_error;
  logic        framing_error;
  logic        overrun;
  logic        baudclk;

  int n_vec = 0;
  int n_err = 0;
  int bc_cnt = 0;
  logic [7:0] data_q[$];
  logic [2:0] err_q[$];   // {parity, framing, overrun}

  localparam logic [2:0] E_PAR = 3'b100;
  localparam logic [2:0] E_FRM = 3'b010;
  localparam logic [2:0] E_OVR = 3'b001;

  always #5 clk = ~clk;

  axi_uart_rx #(.SIZE(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .o_tdata       (o_tdata),
    .o_tvalid      (o_tvalid),
    .o_tready      (o_tready),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .clkdiv        (clkdiv),
    .fifo_level    (fifo_level),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun),
    .baudclk       (baudclk)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bit_out(input logic b, input int div);
    rx = b;
    tick(div);
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    bit_out(1'b0, div);
    for (int i = 0; i < 8; i++) bit_out(d[i], div);
    if (par_en) bit_out(par_bit, div);
    bit_out(stop_bit, div);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (data_q.size() == 0 && err_q.size() == 0) break;
      tick(1);
    end
    check("drain_data_q", 32'(data_q.size()), 32'd0);
    check("drain_err_q", 32'(err_q.size()), 32'd0);
  endtask

  task automatic mon_loop();
    logic [2:0] w;
    logic [7:0] e;
    logic [2:0] ek;
    forever begin
      @(negedge clk);
      if (baudclk) bc_cnt++;
      w = {parity_error, framing_error, overrun};
      if (w != 3'b000) begin
        if (err_q.size() == 0) check("err_without_expect", 32'(err_q.size()), 32'd1);
        else begin
          ek = err_q.pop_front();
          check("err_kind", 32'(w), 32'(ek));
        end
      end
      if (o_tvalid && o_tready) begin
        if (data_q.size() == 0) check("pop_without_expect", 32'(data_q.size()), 32'd1);
        else begin
          e = data_q.pop_front();
          check("pop_data", 32'(o_tdata), 32'(e));
        end
      end
    end
  endtask

  // Loopback bytes at clkdiv=10, even parity: parity bit = ^data
  logic [7:0] lb_bytes [3] = '{8'hA3, 8'h00, 8'hFF};
  logic       lb_par   [3] = '{1'b0, 1'b0, 1'b0};

  initial begin
    int n0;
    logic [7:0] d;
    rst = 1'b1; rx = 1'b1; o_tready = 1'b0;
    parity_enable = 1'b0; parity_type = 1'b0; clkdiv = 16'd16;
    fork mon_loop(); join_none
    tick(3);
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_pulses", 32'({parity_error, framing_error, overrun}), 32'd0);
    check("rst_baudclk", 32'(baudclk), 32'd0);
    rst = 1'b0;
    tick(5);

    // 1: plain 0x55, held in FIFO then drained
    n0 = bc_cnt;
    data_q.push_back(8'h55);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1);
    tick(2);
    check("t1_baudclk_count", 32'(bc_cnt - n0), 32'd10);
    check("t1_level", 32'(fifo_level), 32'd1);
    o_tready = 1'b1;
    wait_drain(20);

    // 2: back-to-back even-parity frames at clkdiv=10
    clkdiv = 16'd10; parity_enable = 1'b1; parity_type = 1'b0;
    for (int i = 0; i < 3; i++) data_q.push_back(lb_bytes[i]);
    for (int i = 0; i < 3; i++) send_frame(lb_bytes[i], 10, 1'b1, lb_par[i], 1'b1);
    tick(10);
    wait_drain(50);

    // 3: odd parity, 0x01 needs parity 0, send 1
    clkdiv = 16'd16; parity_type = 1'b1;
    err_q.push_back(E_PAR);
    send_frame(8'h01, 16, 1'b1, 1'b1, 1'b1);
    tick(10);
    check("t3_level", 32'(fifo_level), 32'd0);
    wait_drain(20);
    parity_enable = 1'b0; parity_type = 1'b0;

    // 4: framing error, line held low, then a clean frame
    err_q.push_back(E_FRM);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0);
    bit_out(1'b0, 40);
    bit_out(1'b1, 20);
    check("t4_level_after_break", 32'(fifo_level), 32'd0);
    data_q.push_back(8'h55);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1);
    tick(10);
    wait_drain(20);

    // 5: 5-cycle glitch is a false start, then 0x3C
    n0 = bc_cnt;
    bit_out(1'b0, 5);
    bit_out(1'b1, 40);
    check("t5_glitch_samples", 32'(bc_cnt - n0), 32'd1);
    check("t5_level", 32'(fifo_level), 32'd0);
    data_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1);
    tick(10);
    wait_drain(20);

    // 6: depth-2 FIFO overrun, drain, then reset mid-frame
    o_tready = 1'b0;
    data_q.push_back(8'hA1);
    data_q.push_back(8'hB2);
    err_q.push_back(E_OVR);
    send_frame(8'hA1, 16, 1'b0, 1'b0, 1'b1);
    send_frame(8'hB2, 16, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1);
    tick(4);
    check("t6_level_full", 32'(fifo_level), 32'd2);
    check("t6_err_seen", 32'(err_q.size()), 32'd0);
    o_tready = 1'b1;
    wait_drain(20);
    check("t6_level_drained", 32'(fifo_level), 32'd0);

    o_tready = 1'b0;
    send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1);
    tick(4);
    check("t6_level_before_rst", 32'(fifo_level), 32'd1);
    d = 8'hF0;
    bit_out(1'b0, 16);
    for (int i = 0; i < 5; i++) bit_out(d[i], 16);
    rx = 1'b1;
    tick(6);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("t6_level_after_rst", 32'(fifo_level), 32'd0);
    check("t6_tvalid_after_rst", 32'(o_tvalid), 32'd0);
    tick(8 + 48 + 30);
    check("t6_level_no_spurious", 32'(fifo_level), 32'd0);
    o_tready = 1'b1;
    tick(10);
    check("final_data_q", 32'(data_q.size()), 32'd0);
    check("final_err_q", 32'(err_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_uart_rx.md
Name: axi_uart_rx

Overview:
UART receiver: the counterpart of axi_uart_tx on the same serial link. It deserialises the rx line into 8-bit characters and pushes them into an AXI-stream FIFO for the consumer. Frame format, parity convention and clkdiv semantics match axi_uart_tx exactly, so a TX/RX pair with equal settings loops back cleanly.

Parameters:
SIZE, 0, log2 depth of the output axi_fifo. Same meaning as in axi_uart_tx.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx  in  1  asynchronous serial input, idle high
o_tdata  out  8  received character
o_tvalid  out  1  FIFO not empty
o_tready  in  1  consumer pop
parity_enable  in  1  1 = one parity bit between the data bits and the stop bit
parity_type  in  1  expected parity = (^data) ^ parity_type; 0 = even, 1 = odd
clkdiv  in  16  clk cycles per bit; must be >= 4 (smaller values are undefined)
fifo_level  out  16  FIFO occupancy (axi_fifo occupied)
parity_error  out  1  one-cycle pulse
framing_error  out  1  one-cycle pulse
overrun  out  1  one-cycle pulse
baudclk  out  1  debug strobe, high on each sample cycle

Behaviour:
- Reset: all pulse outputs 0; state IDLE; counters 0; FIFO empty, so o_tvalid = 0 and fifo_level = 0.
- rx passes through a 2-flop synchroniser (rx_s). A third register rx_d holds the previous value of rx_s.
- Start edge: rx_d = 1 and rx_s = 0 while in IDLE.
- On the start edge: baud_ctr <= 1 and the state moves to START.
- In every non-IDLE state, baud_ctr increments each cycle.

State machine:
- IDLE: wait for a start edge. A line held low, such as a break or the tail of a framing error, never re-arms; rx_s must return high first.
- START: when baud_ctr == clkdiv>>1 (mid-bit), sample rx_s.
  - If rx_s = 1: false start; go to IDLE with no error.
  - If rx_s = 0: set baud_ctr <= 1, bit_idx <= 0, and go to DATA.
- DATA: when baud_ctr == clkdiv, shift rx_s into shreg[bit_idx] (LSB first) and set baud_ctr <= 1.
  - After bit_idx 7, go to PARITY if parity_enable, else to STOP.
- PARITY: when baud_ctr == clkdiv, latch par_bad = rx_s ^ (^shreg) ^ parity_type, set baud_ctr <= 1, and go to STOP.
- STOP: when baud_ctr == clkdiv, sample rx_s and go to IDLE in the same cycle (mid-stop-bit), ready for back-to-back frames.
  - Stop = 0: framing_error pulse, no push. A framing error takes priority over a parity error.
  - Stop = 1 and par_bad: parity_error pulse, no push.
  - Otherwise, if the FIFO is full: overrun pulse; the character is dropped and the FIFO is unchanged.
  - Otherwise: push shreg into the FIFO.
  - The error pulses and the push strobe are registered and assert the cycle after the stop sample.
- parity_enable, parity_type and clkdiv are sampled live and must be held stable during a frame; behaviour if they change mid-frame is undefined.
- baudclk is high on each mid-bit sample cycle: START, DATA, PARITY and STOP.
- Push and pop in the same cycle are handled by axi_fifo; no characters are lost.
- rst mid-frame: the current partial character is discarded, the FIFO is flushed, and the state returns to IDLE. The remainder of the interrupted frame may produce a false start; because it fails the start check or the framing check, no spurious push occurs except through data aliasing.

Decomposition:
- Reuse the existing axi_fifo (WIDTH 8, SIZE) as the only sub-instance.
- Put the state encoding (IDLE, START, DATA, PARITY, STOP) in a shared uart package as localparams, so that future TX refactors use the same encoding.
- The synchroniser is inline (3 flops); no separate module.

Test Plan:
1. clkdiv=16, no parity, drive frame 0x55 (start, 10101010, stop, 16 cycles/bit) -> one push; o_tdata = 0x55; no error pulses; fifo_level = 1.
2. Loopback through axi_uart_tx with clkdiv=10, parity_enable=1, parity_type=0, bytes 0xA3, 0x00, 0xFF back-to-back -> same three bytes in order; parity_error never asserts.
3. parity_enable=1, parity_type=1, send 0x01 with parity bit 1 (expected 0) -> parity_error pulses once; no push; fifo_level stays 0.
4. clkdiv=16, stop bit driven 0 then rx held low for 40 cycles -> framing_error pulses once. A second 0x55 frame started only after rx returns high -> received correctly.
5. Glitch: rx low for 5 cycles with clkdiv=16 -> no push and no errors; state back in IDLE. A following 0x3C frame -> received correctly.
6. SIZE=1, o_tready=0, send 3 frames -> first 2 bytes stored, overrun pulses on the third. Then o_tready=1 -> the first two bytes drain in order. rst asserted mid-frame -> fifo_level = 0 and no spurious push.
